// File: rtl/camera_pkg.sv
// Shared defaults and types for the camera stream blocks.
package camera_pkg;

    localparam int unsigned PIX_W_DEF    = 16;
    localparam int unsigned DATA_W_DEF   = 64;
    localparam int unsigned PIX_PER_BEAT = DATA_W_DEF / PIX_W_DEF;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        LINE,
        LGAP,
        TAIL
    } player_state_t;

endpackage

// File: rtl/axis_frame_player_if.sv
// AXI-Stream beat bus between the MM2S source and the frame player.
interface axis_frame_player_if #(
    parameter int unsigned DATA_W = camera_pkg::DATA_W_DEF
);

    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/axis_beat_unpack.sv
// DATA_W -> PIX_W gearbox; a single beat register doubles as the skid buffer.
module axis_beat_unpack #(
    parameter int unsigned DATA_W = camera_pkg::DATA_W_DEF,
    parameter int unsigned PIX_W  = camera_pkg::PIX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready_c,
    output logic [PIX_W-1:0]  pix,
    output logic              pix_valid,
    input  logic              pix_ready
);

    localparam int unsigned PPB   = DATA_W / PIX_W;
    localparam int unsigned IDX_W = (PPB > 1) ? $clog2(PPB) : 1;

    logic [PPB-1:0][PIX_W-1:0] beat_q;
    logic                      full_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      pop_c;
    logic                      last_c;
    logic                      accept_c;

    // Refill in the same cycle the last pixel leaves so lines run gap-free.
    assign last_c     = (idx_q == IDX_W'(PPB - 1));
    assign pop_c      = full_q && pix_ready;
    assign s_tready_c = enable && (!full_q || (pop_c && last_c));
    assign accept_c   = s_tvalid && s_tready_c;
    assign pix        = beat_q[idx_q];
    assign pix_valid  = full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            full_q <= 1'b0;
            idx_q  <= '0;
        end else if (accept_c) begin
            beat_q <= s_tdata;
            full_q <= 1'b1;
            idx_q  <= '0;
        end else if (pop_c) begin
            if (last_c) full_q <= 1'b0;
            else        idx_q  <= idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/axis_frame_player.sv
// Replays a DDR image from AXI-Stream as an FVAL/LVAL/DVAL framed pixel stream.
// Optional FRAME_PLAYER_PATTERN_EN adds a test_mode input selecting a ramp source.
module axis_frame_player
    import camera_pkg::*;
#(
    parameter int unsigned PIX_W     = PIX_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned LINE_GAP  = 16,
    parameter int unsigned FRAME_GAP = 64
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
`ifdef FRAME_PLAYER_PATTERN_EN
    input  logic               test_mode,
`endif
    input  logic [15:0]        image_width,
    input  logic [15:0]        image_height,
    axis_frame_player_if.slave s_axis,
    output logic [PIX_W-1:0]   pix_data,
    output logic               fval,
    output logic               lval,
    output logic               dval,
    output logic               busy,
    output logic               done,
    output logic               frame_err
);

    localparam int unsigned PPB = DATA_W / PIX_W;

    player_state_t state_q;
    logic [15:0]   width_q, height_q;
    logic [31:0]   gap_cnt_q, pix_cnt_q, line_cnt_q, beats_left_q;
    logic          test_q;

    logic             unpack_en_c, unpack_valid, unpack_ready_c;
    logic [PIX_W-1:0] unpack_pix, ramp_c, src_pix_c;
    logic             src_valid_c, pop_c, accept_c, beat_bad_c;
    logic             gap_end_c, line_open_c, more_lines_c, want_pix_c, enter_line_c, dims_ok_c;

`ifdef FRAME_PLAYER_PATTERN_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                    test_q <= 1'b0;
        else if (state_q == IDLE && start) test_q <= test_mode;
    end
`else
    assign test_q = 1'b0;
`endif

    assign dims_ok_c    = (image_width != 16'd0) && (image_height != 16'd0);
    assign gap_end_c    = (gap_cnt_q == 32'(LINE_GAP - 1));
    assign line_open_c  = (state_q == LINE) && (pix_cnt_q != 32'(width_q));
    assign more_lines_c = (line_cnt_q < 32'(height_q));
    assign enter_line_c = gap_end_c && ((state_q == LEAD) || (state_q == LGAP && more_lines_c));
    assign want_pix_c   = enter_line_c || line_open_c;

    assign unpack_en_c    = (state_q == LEAD || state_q == LINE || state_q == LGAP)
                            && (beats_left_q != 32'd0) && !test_q;
    assign unpack_ready_c = want_pix_c && !test_q;

    assign ramp_c      = PIX_W'(line_cnt_q + (line_open_c ? pix_cnt_q : 32'd0));
    assign src_valid_c = test_q ? 1'b1 : unpack_valid;
    assign src_pix_c   = test_q ? ramp_c : unpack_pix;
    assign pop_c       = want_pix_c && src_valid_c;

    assign accept_c   = s_axis.tvalid && s_axis.tready;
    assign beat_bad_c = (s_axis.tlast != (beats_left_q == 32'd1)) || (s_axis.tkeep != '1);

    axis_beat_unpack #(
        .DATA_W (DATA_W),
        .PIX_W  (PIX_W)
    ) u_unpack (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .enable     (unpack_en_c),
        .s_tdata    (s_axis.tdata),
        .s_tvalid   (s_axis.tvalid),
        .s_tready_c (s_axis.tready),
        .pix        (unpack_pix),
        .pix_valid  (unpack_valid),
        .pix_ready  (unpack_ready_c)
    );

    // Frame sequencer; framing outputs are registered alongside the state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            gap_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            beats_left_q <= '0;
            pix_data     <= '0;
            fval         <= 1'b0;
            lval         <= 1'b0;
            dval         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                beats_left_q <= beats_left_q - 32'd1;
                if (beat_bad_c) frame_err <= 1'b1;
            end
            unique case (state_q)
                IDLE: if (start) begin
                    frame_err <= 1'b0;
                    if (dims_ok_c) begin
                        width_q      <= image_width;
                        height_q     <= image_height;
                        beats_left_q <= (32'(image_width) * 32'(image_height)) / 32'(PPB);
                        gap_cnt_q    <= '0;
                        line_cnt_q   <= '0;
                        fval         <= 1'b1;
                        busy         <= 1'b1;
                        state_q      <= LEAD;
                    end else begin
                        done <= 1'b1;
                    end
                end
                LEAD: begin
                    if (gap_end_c) state_q   <= LINE;
                    else           gap_cnt_q <= gap_cnt_q + 32'd1;
                end
                LINE: begin
                    if (line_open_c) begin
                        dval <= pop_c;
                        if (pop_c) begin
                            pix_cnt_q <= pix_cnt_q + 32'd1;
                            pix_data  <= src_pix_c;
                        end
                    end else begin
                        lval       <= 1'b0;
                        dval       <= 1'b0;
                        line_cnt_q <= line_cnt_q + 32'd1;
                        gap_cnt_q  <= '0;
                        state_q    <= LGAP;
                    end
                end
                LGAP: begin
                    if (!gap_end_c) begin
                        gap_cnt_q <= gap_cnt_q + 32'd1;
                    end else if (more_lines_c) begin
                        state_q <= LINE;
                    end else begin
                        fval      <= 1'b0;
                        gap_cnt_q <= '0;
                        state_q   <= TAIL;
                    end
                end
                TAIL: begin
                    if (gap_cnt_q == 32'(FRAME_GAP - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // First pixel of a line is fetched on the same edge lval rises.
            if (enter_line_c) begin
                lval      <= 1'b1;
                dval      <= pop_c;
                pix_cnt_q <= 32'(pop_c);
                if (pop_c) pix_data <= src_pix_c;
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_player.sv
// Directed bench for axis_frame_player: framing timing, starvation, errors, reset.
module tb_axis_frame_player;
    import camera_pkg::*;

    localparam int unsigned PW      = PIX_W_DEF;
    localparam int          MAX_CYC = 400;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [15:0] image_width, image_height;
    logic [PW-1:0] pix_data;
    logic        fval, lval, dval, busy, done, frame_err;
`ifdef FRAME_PLAYER_PATTERN_EN
    logic        test_mode;
`endif

    always #5 sys_clk = ~sys_clk;

    axis_frame_player_if #(.DATA_W(DATA_W_DEF)) s_axis ();

    axis_frame_player dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
`ifdef FRAME_PLAYER_PATTERN_EN
        .test_mode    (test_mode),
`endif
        .image_width  (image_width),
        .image_height (image_height),
        .s_axis       (s_axis),
        .pix_data     (pix_data),
        .fval         (fval),
        .lval         (lval),
        .dval         (dval),
        .busy         (busy),
        .done         (done),
        .frame_err    (frame_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Per-frame observations.
    logic [DATA_W_DEF-1:0] beat_mem [17];
    logic                  last_mem [17];
    int first_fval, fall_n, done_n, beats_acc, starve, starve_px, busy_cyc, n_lines;
    int lval_rise [4];
    int lval_len  [4];
    logic [PW-1:0] pix_q [$];
    bit seen_lval, seen_busy, seen_tready, prev_lval, prev_fval;

    task automatic sample(input int m);
        if (s_axis.tready) seen_tready = 1'b1;
        if (busy) begin
            seen_busy = 1'b1;
            busy_cyc++;
        end
        if (fval && first_fval < 0) first_fval = m;
        if (!fval && prev_fval && fall_n < 0) fall_n = m;
        if (lval) begin
            seen_lval = 1'b1;
            if (!prev_lval && n_lines < 4) begin
                lval_rise[n_lines] = m;
                n_lines++;
            end
            if (n_lines > 0) lval_len[n_lines-1]++;
        end
        if (dval) pix_q.push_back(pix_data);
        else if (lval) begin
            starve++;
            if (starve == 1) starve_px = int'(pix_data);
        end
        if (done) done_n = m;
        prev_lval = lval;
        prev_fval = fval;
    endtask

    task automatic run_frame(input int w, input int h, input int tlast_beat, input bit sparse,
                             input int bad_keep_beat, input int base, input int abort_at);
        int nb;
        int bi;
        bit acc;
        nb = (w * h) / int'(PIX_PER_BEAT) + 2;
        if (nb > 16) nb = 16;
        for (int b = 0; b < 17; b++) begin
            for (int j = 0; j < int'(PIX_PER_BEAT); j++)
                beat_mem[b][j*PW +: PW] = PW'(base + b * int'(PIX_PER_BEAT) + j);
            last_mem[b] = (b + 1 == tlast_beat);
        end
        first_fval = -1; fall_n = -1; done_n = -1; starve_px = -1;
        beats_acc = 0; starve = 0; busy_cyc = 0; n_lines = 0;
        for (int i = 0; i < 4; i++) begin
            lval_rise[i] = -1;
            lval_len[i]  = 0;
        end
        pix_q.delete();
        seen_lval = 0; seen_busy = 0; seen_tready = 0; prev_lval = 0; prev_fval = 0;
        image_width  = 16'(w);
        image_height = 16'(h);
        bi = 0;
        for (int n = 0; n <= MAX_CYC; n++) begin
            start         = (n == 0);
            s_axis.tvalid = (bi < nb) && (!sparse || (n % 3 == 0));
            s_axis.tdata  = beat_mem[bi];
            s_axis.tlast  = last_mem[bi];
            s_axis.tkeep  = (bi + 1 == bad_keep_beat) ? 8'h7F : 8'hFF;
            #2;
            acc = s_axis.tvalid && s_axis.tready;
            @(posedge sys_clk);
            #1;
            if (acc) begin
                bi++;
                beats_acc++;
            end
            sample(n + 1);
            if (done || (abort_at > 0 && n + 1 == abort_at)) break;
        end
        start = 1'b0;
    endtask

    task automatic check_pix(input string tag, input int base, input int cnt);
        check_eq({tag, "_npix"}, pix_q.size(), cnt);
        for (int i = 0; i < cnt && i < pix_q.size(); i++)
            check_eq($sformatf("%s_pix%0d", tag, i), pix_q[i], PW'(base + i));
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_fval"}, fval, 0);
        check_eq({tag, "_lval"}, lval, 0);
        check_eq({tag, "_dval"}, dval, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_tready"}, s_axis.tready, 0);
        check_eq({tag, "_pix"}, pix_data, 0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        start = 1'b0;
        image_width = '0;
        image_height = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata = '0;
        s_axis.tkeep = '1;
        s_axis.tlast = 1'b0;
`ifdef FRAME_PLAYER_PATTERN_EN
        test_mode = 1'b0;
`endif
        #12;
        check_zero_outputs("rst");
        check_eq("rst_done", done, 0);
        check_eq("rst_err", frame_err, 0);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        // Clean 8x2 frame, stream always valid.
        run_frame(8, 2, 4, 1'b0, 0, 16'h0100, 0);
        check_eq("clean_fval_lat", first_fval, 1);
        check_eq("clean_lead", lval_rise[0] - first_fval, 16);
        check_eq("clean_len0", lval_len[0], 8);
        check_eq("clean_len1", lval_len[1], 8);
        check_eq("clean_lgap", lval_rise[1] - lval_rise[0] - lval_len[0], 16);
        check_eq("clean_fval_fall", fall_n, 65);
        check_eq("clean_done", done_n, 129);
        check_eq("clean_busy", busy_cyc, 128);
        check_eq("clean_starve", starve, 0);
        check_eq("clean_beats", beats_acc, 4);
        check_eq("clean_err", frame_err, 0);
        check_pix("clean", 16'h0100, 16);

        // Same frame, tvalid one cycle in three.
        run_frame(8, 2, 4, 1'b1, 0, 16'h0200, 0);
        check_eq("sparse_len0", lval_len[0], 10);
        check_eq("sparse_len1", lval_len[1], 8);
        check_eq("sparse_starve", starve, 2);
        check_eq("sparse_hold_px", starve_px, 16'h0203);
        check_eq("sparse_fval_fall", fall_n, 67);
        check_eq("sparse_done", done_n, 131);
        check_eq("sparse_beats", beats_acc, 4);
        check_eq("sparse_err", frame_err, 0);
        check_pix("sparse", 16'h0200, 16);

        // Early tlast on beat 2: frame completes, error sticks.
        run_frame(8, 2, 2, 1'b0, 0, 16'h0300, 0);
        check_eq("tlast_done", done_n, 129);
        check_eq("tlast_beats", beats_acc, 4);
        check_eq("tlast_err", frame_err, 1);
        check_pix("tlast", 16'h0300, 16);

        // Next clean start clears the sticky error.
        run_frame(8, 2, 4, 1'b0, 0, 16'h0400, 0);
        check_eq("clr_err_at_start", (first_fval == 1) ? 0 : 1, 0);
        check_eq("clr_done", done_n, 129);
        check_eq("clr_err", frame_err, 0);

        // Partial tkeep on beat 3.
        run_frame(8, 2, 4, 1'b0, 3, 16'h0500, 0);
        check_eq("keep_done", done_n, 129);
        check_eq("keep_err", frame_err, 1);

        // Zero width: immediate done, nothing else moves.
        run_frame(0, 2, 1, 1'b0, 0, 16'h0600, 0);
        check_eq("w0_done", done_n, 1);
        check_eq("w0_fval", first_fval, -1);
        check_eq("w0_lval", seen_lval, 0);
        check_eq("w0_busy", seen_busy, 0);
        check_eq("w0_tready", seen_tready, 0);
        check_eq("w0_err", frame_err, 0);

        // Zero height behaves the same.
        run_frame(8, 0, 1, 1'b0, 0, 16'h0700, 0);
        check_eq("h0_done", done_n, 1);
        check_eq("h0_fval", first_fval, -1);
        check_eq("h0_beats", beats_acc, 0);

        // Reset asserted during line 2.
        run_frame(8, 2, 4, 1'b0, 0, 16'h0800, 45);
        check_eq("midrst_in_line", lval, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        s_axis.tvalid = 1'b0;
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        run_frame(8, 2, 4, 1'b0, 0, 16'h0900, 0);
        check_eq("postrst_done", done_n, 129);
        check_eq("postrst_beats", beats_acc, 4);
        check_eq("postrst_err", frame_err, 0);
        check_pix("postrst", 16'h0900, 16);

`ifdef FRAME_PLAYER_PATTERN_EN
        // Internal ramp source ignores the stream.
        test_mode = 1'b1;
        run_frame(4, 2, 2, 1'b0, 0, 16'h0A00, 0);
        test_mode = 1'b0;
        check_eq("pat_tready", seen_tready, 0);
        check_eq("pat_beats", beats_acc, 0);
        check_eq("pat_len0", lval_len[0], 4);
        check_eq("pat_len1", lval_len[1], 4);
        check_eq("pat_done", done_n, 121);
        check_eq("pat_npix", pix_q.size(), 8);
        for (int i = 0; i < 8 && i < pix_q.size(); i++)
            check_eq($sformatf("pat_pix%0d", i), pix_q[i], (i / 4) + (i % 4));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_frame_player.md
Name: axis_frame_player

Overview:
- Transmit-side counterpart of the camera receiver.
- Consumes the DMA MM2S AXI-Stream (64-bit beats from DDR) and replays the image as a Camera Link-style pixel stream with FVAL/LVAL/DVAL framing.
- Feeds loopback/self-test of the camera receive path and emulates the Hawk/Owl sensors on the bench.
- Sits in the sys_clk domain between the CPU system MM2S port and the camera pixel input.

Parameters:
- PIX_W, 16, pixel width; DATA_W/PIX_W pixels per beat.
- DATA_W, 64, AXI-Stream data width; must be a multiple of PIX_W.
- LINE_GAP, 16, sys_clk cycles with LVAL low between lines, and from FVAL rise to the first LVAL.
- FRAME_GAP, 64, sys_clk cycles FVAL held low after a frame before done.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; launches one frame when idle.
- image_width  in  16  pixels per line; must be a non-zero multiple of DATA_W/PIX_W.
- image_height  in  16  lines per frame.
- s_axis_tdata  in  DATA_W  MM2S data; pixel 0 in bits [PIX_W-1:0].
- s_axis_tkeep  in  DATA_W/8  ignored except for error check; all ones expected.
- s_axis_tlast  in  1  end of frame marker.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid&tready.
- pix_data  out  PIX_W  pixel output.
- fval  out  1  frame valid.
- lval  out  1  line valid.
- dval  out  1  pixel valid.
- busy  out  1  high from the start accept until done.
- done  out  1  one-cycle pulse at the end of a frame.
- frame_err  out  1  sticky; cleared on the next accepted start.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and the unpack buffer is empty.
- Asynchronous assert; all state clears immediately.
- States: IDLE -> LEAD -> LINE -> LGAP -> (LINE | TAIL) -> IDLE.
- IDLE:
  - start with both dims non-zero: latch dims, assert busy and fval next cycle, enter LEAD.
  - start with either dim 0: done pulse next cycle; no fval; busy stays 0.
  - start while busy is ignored.
- LEAD: fval=1 and lval=0 for LINE_GAP cycles, then LINE.
- LINE:
  - lval=1 for the whole line.
  - Each cycle the unpacker holds a pixel: dval=1, pix_data=pixel, pixel counter +1.
  - Stream starved: dval=0 and pix_data holds its last value; lval stays 1 (stretched line).
  - pixel counter == image_width-1 with dval: go to LGAP, line counter +1.
- LGAP: lval=0 for LINE_GAP cycles. Then LINE if the line counter < image_height, else TAIL.
- TAIL:
  - fval drops on TAIL entry and stays low FRAME_GAP cycles.
  - Then done pulse, busy=0, IDLE.
- Pixel order: PIX_W slices of the beat, LSB first, one pixel per cycle.
- s_axis_tready:
  - high only in LEAD/LINE/LGAP, when the unpack buffer is empty or will empty this cycle.
  - Never high in IDLE or TAIL.
  - Sustained throughput is one pixel per cycle; one beat of skid buffer.
- Total beats consumed = image_width*image_height/(DATA_W/PIX_W).
- Internal counters are 32-bit, so 16x16 products do not overflow.
- frame_err sets when any of these occur:
  - tlast on a beat other than the last of the frame; the beat is still consumed and the frame continues.
  - no tlast on the last beat.
  - tkeep not all ones.
- Extra beats after the frame are not consumed (tready=0).
- Reset mid-frame: outputs drop to 0 asynchronously. Any partially read DMA stream is the software's responsibility to flush.

Optional Feature:
- Macro FRAME_PLAYER_PATTERN_EN.
- Defined:
  - adds input test_mode (1 bit), sampled at start.
  - test_mode=1: s_axis_tready is held 0 and pixels come from an internal ramp, pix = (line + col) mod 2^PIX_W; dval is 1 for every LINE cycle.
  - test_mode=0: behaviour as above.
- Undefined: no test_mode port; stream source only.

Decomposition:
- Package camera_pkg:
  - PIX_W/DATA_W defaults.
  - PIX_PER_BEAT constant.
  - player_state_t enum {IDLE, LEAD, LINE, LGAP, TAIL}.
- Sub-module axis_beat_unpack: DATA_W->PIX_W gearbox with a one-beat skid register.
  - Ports: s_axis handshake in; pix/pix_valid/pix_ready out.
  - Owns tready generation.
- Top: FSM, gap/pixel/line counters, framing outputs, error checks.

Test Plan:
- Width 8, height 2, stream always valid, tlast on beat 4 -> fval 1 cycle after start.
  - 16 LINE_GAP cycles, then lval 8 cycles with dval continuous, pixels 0..7 in LSB-first order.
  - LGAP 16, second line 8 cycles, then fval low 64 cycles.
  - done pulse, frame_err=0.
- Same frame with tvalid toggling 1-in-3 -> lval stretched, dval low while starved, identical pixel sequence, 4 beats accepted total.
- Width 8, height 2 with tlast on beat 2 -> frame completes normally, frame_err=1. The next start clears frame_err to 0.
- start with width=0 -> done pulse next cycle, fval/lval/busy never assert, tready stays 0.
- Assert sys_rst_n low during line 2 -> fval/lval/dval/busy/tready go 0 asynchronously. After release, a new start plays a full clean frame.
- FRAME_PLAYER_PATTERN_EN defined, test_mode=1, width 4, height 2 -> pixels 0,1,2,3 then 1,2,3,4; tready stays 0.
